// File: rtl/morse_sequence_collector.sv
// Morse sequence collector: packs dot/dash symbols into three 10-bit slots,
// hands the 30-bit word to the translator and waits for its acknowledge.
module morse_sequence_collector #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_symbol_valid,
  input  logic        i_symbol_is_dash,
  input  logic        i_char_end,
  input  logic        i_flush,
  input  logic        i_transmit,
  output logic [29:0] o_sequences,
  output logic        o_storage_sent,
  output logic        o_busy,
  output logic        o_err_overflow,
  output logic        o_err_dropped,
  output logic        o_err_timeout
);

  typedef enum logic [1:0] {StCollect, StSend, StWait} state_e;

  localparam logic [9:0]  SlotNull    = 10'h3FF;
  localparam logic [29:0] SeqNull     = 30'h3FFF_FFFF;
  localparam logic [7:0]  TimeoutLast = 8'(ACK_TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic [9:0]  r_acc, w_acc_d;
  logic [2:0]  r_sc, w_sc_d;
  logic        r_bad, w_bad_d;
  logic [1:0]  r_ci, w_ci_d;
  logic [29:0] r_seq, w_seq_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        r_storage_sent, w_storage_sent_d;
  logic        r_busy, w_busy_d;
  logic        r_err_overflow, w_err_overflow_d;
  logic        r_err_dropped, w_err_dropped_d;
  logic        r_err_timeout, w_err_timeout_d;
  logic        w_commit;
  logic        w_exit;
  logic [9:0]  w_char;

  // Next-state logic: symbol, then commit, then flush within one cycle.
  always_comb begin
    w_state_d        = r_state;
    w_acc_d          = r_acc;
    w_sc_d           = r_sc;
    w_bad_d          = r_bad;
    w_ci_d           = r_ci;
    w_seq_d          = r_seq;
    w_cnt_d          = r_cnt;
    w_err_overflow_d = 1'b0;
    w_err_dropped_d  = 1'b0;
    w_err_timeout_d  = 1'b0;
    w_commit         = 1'b0;
    w_exit           = 1'b0;
    w_char           = SlotNull;

    unique case (r_state)
      StCollect: begin
        if (i_symbol_valid) begin
          if (r_sc < 3'd5) begin
            case (r_sc)
              3'd0:    w_acc_d[9:8] = {1'b0, i_symbol_is_dash};
              3'd1:    w_acc_d[7:6] = {1'b0, i_symbol_is_dash};
              3'd2:    w_acc_d[5:4] = {1'b0, i_symbol_is_dash};
              3'd3:    w_acc_d[3:2] = {1'b0, i_symbol_is_dash};
              default: w_acc_d[1:0] = {1'b0, i_symbol_is_dash};
            endcase
            w_sc_d = r_sc + 3'd1;
          end else if (!r_bad) begin
            // Only the 6th symbol reports; later ones are silently ignored.
            w_bad_d          = 1'b1;
            w_err_overflow_d = 1'b1;
          end
        end

        // A flush commits a pending character implicitly.
        w_commit = (i_char_end || i_flush) && (w_sc_d != 3'd0);
        if (w_commit) begin
          w_char = w_bad_d ? SlotNull : w_acc_d;
          case (r_ci)
            2'd0:    w_seq_d[29:20] = w_char;
            2'd1:    w_seq_d[19:10] = w_char;
            default: w_seq_d[9:0]   = w_char;
          endcase
          w_acc_d = SlotNull;
          w_sc_d  = 3'd0;
          w_bad_d = 1'b0;
          if (r_ci == 2'd2) begin
            w_state_d = StSend;
          end else begin
            w_ci_d = r_ci + 2'd1;
          end
        end

        if (i_flush && (w_ci_d != 2'd0)) begin
          w_state_d = StSend;
        end
      end

      StSend: begin
        w_err_dropped_d = i_symbol_valid || i_char_end || i_flush;
        w_cnt_d         = 8'd0;
        w_state_d       = StWait;
      end

      StWait: begin
        w_err_dropped_d = i_symbol_valid || i_char_end || i_flush;
        if (i_transmit) begin
          w_exit = 1'b1;
        end else if (r_cnt == TimeoutLast) begin
          w_exit          = 1'b1;
          w_err_timeout_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_d = StCollect;
      end
    endcase

    if (w_exit) begin
      w_state_d = StCollect;
      w_seq_d   = SeqNull;
      w_ci_d    = 2'd0;
      w_acc_d   = SlotNull;
      w_sc_d    = 3'd0;
      w_bad_d   = 1'b0;
      w_cnt_d   = 8'd0;
    end

    // Outputs are registered from the next state so they line up with it.
    w_storage_sent_d = (w_state_d == StSend);
    w_busy_d         = (w_state_d != StCollect);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StCollect;
      r_acc          <= SlotNull;
      r_sc           <= 3'd0;
      r_bad          <= 1'b0;
      r_ci           <= 2'd0;
      r_seq          <= SeqNull;
      r_cnt          <= 8'd0;
      r_storage_sent <= 1'b0;
      r_busy         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_dropped  <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_acc          <= w_acc_d;
      r_sc           <= w_sc_d;
      r_bad          <= w_bad_d;
      r_ci           <= w_ci_d;
      r_seq          <= w_seq_d;
      r_cnt          <= w_cnt_d;
      r_storage_sent <= w_storage_sent_d;
      r_busy         <= w_busy_d;
      r_err_overflow <= w_err_overflow_d;
      r_err_dropped  <= w_err_dropped_d;
      r_err_timeout  <= w_err_timeout_d;
    end
  end

  assign o_sequences    = r_seq;
  assign o_storage_sent = r_storage_sent;
  assign o_busy         = r_busy;
  assign o_err_overflow = r_err_overflow;
  assign o_err_dropped  = r_err_dropped;
  assign o_err_timeout  = r_err_timeout;

endmodule

// File: doc/morse_sequence_collector.md
# morse_sequence_collector

Collects keyed Morse symbols (dot/dash) into three 10-bit sequence slots and hands the packed 30-bit word to the sequence translator with a one-cycle `storage_sent` strobe. It then waits for the translator's `transmit` acknowledge, or times out, before accepting new input. It sits between the key debouncer/symbol classifier and the translator, and sequences all translator activity.

## Interface
- `ACK_TIMEOUT`, default 16: cycles to wait for `transmit` after `storage_sent` before giving up (range 2–255).
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `symbol_valid` in 1: one-cycle strobe; a symbol is present.
- `symbol_is_dash` in 1: qualifies `symbol_valid`; 1 = dash, 0 = dot.
- `char_end` in 1: one-cycle strobe; letter gap, commits the current character.
- `flush` in 1: one-cycle strobe; word gap, sends whatever is collected.
- `transmit` in 1: acknowledge from the translator.
- `sequences` out 30: packed slots; slot0 = [29:20], slot1 = [19:10], slot2 = [9:0].
- `storage_sent` out 1: one-cycle send strobe to the translator.
- `busy` out 1: high in SEND and WAIT.
- `err_overflow` out 1: one-cycle pulse when a 6th symbol arrives in one character.
- `err_dropped` out 1: one-cycle pulse when any strobe is ignored because `busy` is high.
- `err_timeout` out 1: one-cycle pulse when WAIT expires without `transmit`.

## Operation
- **Symbol encoding:** 2 bits per symbol, first symbol in the MSBs. Dot = 00, dash = 01, unused = 11. Examples: S = 0000001111, O = 0101011111, null/invalid = 1111111111.
- **Accumulator:** 10 bits, reset to all ones, plus a symbol count `sc` (0–5) and a `bad` flag.
  - Symbol k (k = `sc`) writes bits [9-2k:8-2k] = {0, `symbol_is_dash`}.
  - Symbol with `sc` = 5: pulse `err_overflow`, set `bad`. Further symbols are ignored until commit.
- **Commit:** occurs on `char_end` with `sc` > 0.
  - Writes the accumulator (or 1111111111 if `bad`) into slot `ci`, the char index (0–2).
  - Then `ci`+1, accumulator reset to all ones, `sc` = 0, `bad` = 0.
  - `char_end` with `sc` = 0 is a no-op; repeated gaps do not create slots.
- **Same-cycle strobes:** processed in the order symbol, then commit, then flush.
- **States:**
  - COLLECT (reset state): accepts strobes.
    - Go to SEND when a commit fills slot 2.
    - Go to SEND on `flush` with at least one slot committed. A pending `sc` > 0 character is committed implicitly first.
    - `flush` with `ci` = 0 and `sc` = 0 is a no-op.
  - SEND: `storage_sent` = 1 for exactly this one cycle. Go to WAIT.
  - WAIT: timeout counter counts up from 0.
    - `transmit` = 1: go to COLLECT.
    - Counter reaches `ACK_TIMEOUT`-1 with no `transmit`: pulse `err_timeout`, go to COLLECT.
    - On either exit: all slots reset to 1111111111, `ci` = 0, accumulator cleared.
  - In SEND and WAIT, every incoming `symbol_valid`/`char_end`/`flush` is dropped and pulses `err_dropped`.
- **Slot contents:** uncommitted slots hold 1111111111 when sent, so the translator emits null for them.
- **`sequences` stability:** stable from the SEND cycle until the WAIT exit.

## Timing
- **Reset values:** `sequences` = 30'h3FFFFFFF, `storage_sent` = 0, `busy` = 0, all `err_*` = 0. State COLLECT, `ci` = `sc` = 0, timeout counter = 0.
- **Reset mid-operation:** reset in any state aborts immediately; nothing is sent.
- **Outputs:** all registered, no combinational path from input to output.
- **Send latency:** the final commit/flush strobe in cycle N gives `storage_sent` = 1 in cycle N+1. `busy` is also high from cycle N+1.
- **Acknowledge:** the translator registers `transmit` one cycle after it samples `storage_sent`, so a nominal ack arrives in the first WAIT cycle (N+2).
  - `transmit` sampled high in WAIT cycle M: COLLECT and `busy` = 0 in cycle M+1. Strobes are accepted from cycle M+1.
  - `transmit` high while in COLLECT or SEND is ignored.
- **Timeout:** with no ack, `err_timeout` pulses in the cycle after the `ACK_TIMEOUT`th WAIT cycle.
- **Error pulses:** each `err_*` pulse lasts exactly 1 cycle per offending event.

## Test plan
- **Three letters:** key S, `char_end`, O, `char_end`, S, `char_end`; ack 1 cycle after the strobe -> `sequences` = {0000001111, 0101011111, 0000001111}, one `storage_sent` pulse, `busy` clears the cycle after `transmit`.
- **Partial word:** key O, then `flush` without `char_end` -> slot0 = 0101011111, slots 1–2 = 1111111111, `storage_sent` 1 cycle after `flush`.
- **Overflow:** 6 dots then `char_end` -> `err_overflow` pulses once on the 6th dot, slot0 = 1111111111.
- **Timeout:** send, hold `transmit` = 0 with `ACK_TIMEOUT` = 4 -> `err_timeout` after 4 WAIT cycles, `sequences` returns to all ones, `busy` = 0.
- **Busy drop, same-cycle strobes, empty flush:**
  - Symbol strobe during WAIT -> `err_dropped` pulse, no state change.
  - `symbol_valid` (dash) + `char_end` in the same cycle on an empty accumulator -> slot0 = 0111111111.
  - `flush` with nothing collected -> no `storage_sent`.
- **Async reset:** assert `rst_n` low in WAIT mid-cycle -> outputs go to reset values without a clock edge, no spurious `storage_sent` after release.
